// File: rtl/bram_rd_pipe.sv
// Simple dual-port BRAM with a fixed read latency and a matching valid/tag delay line.
// Define BRAM_RDW_FWD_EN for write-first behaviour on same-address read/write; default is read-first.
module bram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TAG_WIDTH  = 16,
    parameter int unsigned RD_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid_out,
    output logic [TAG_WIDTH-1:0]  rd_tag_out
);

    if (RD_LATENCY < 2) begin : gen_lat_check
        $error("bram_rd_pipe: RD_LATENCY must be at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_word;

    // data_q[0] is the RAM output register; the last entry drives rd_data.
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_q;
    logic [TAG_WIDTH-1:0]  tag_q  [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef BRAM_RDW_FWD_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (en) begin
            data_q[0] <= rd_word;
            vld_q     <= {vld_q[RD_LATENCY-2:0], rd_en};
            tag_q[0]  <= rd_tag;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                data_q[i] <= data_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign rd_data      = data_q[RD_LATENCY-1];
    assign rd_valid_out = vld_q[RD_LATENCY-1];
    assign rd_tag_out   = tag_q[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_rd_pipe.sv
// Scoreboard bench for bram_rd_pipe at read latencies 3, 2 and 5 driven by one shared stimulus.
module tb_bram_rd_pipe;

    localparam int unsigned NDUT = 3;
    localparam int unsigned LAT [NDUT] = '{3, 2, 5};

    typedef struct {
        logic [63:0] data;
        logic [15:0] tag;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_tag = '0;

    logic [63:0] dout [NDUT];
    logic        vout [NDUT];
    logic [15:0] tout [NDUT];

    logic [63:0] prev_d [NDUT];
    logic        prev_v [NDUT];
    logic [15:0] prev_t [NDUT];

    exp_t        sb [NDUT][$];
    logic [63:0] model [512];

    int unsigned ecnt = 0;
    logic        last_rst = 1'b0;
    logic        last_en = 1'b0;
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    bram_rd_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .TAG_WIDTH(16), .RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .rd_data(dout[0]), .rd_valid_out(vout[0]), .rd_tag_out(tout[0])
    );

    bram_rd_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .TAG_WIDTH(16), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .rd_data(dout[1]), .rd_valid_out(vout[1]), .rd_tag_out(tout[1])
    );

    bram_rd_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .TAG_WIDTH(16), .RD_LATENCY(5)) u_dut_l5 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .rd_data(dout[2]), .rd_valid_out(vout[2]), .rd_tag_out(tout[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Enabled, non-reset edges; an output due at count N is visible after the edge reaching N.
    always @(posedge clk) begin
        if (!rst && en) ecnt <= ecnt + 1;
        last_rst <= rst;
        last_en  <= en;
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            string sfx;
            sfx = $sformatf("_L%0d", LAT[d]);
            if (last_rst) begin
                check_eq({"rst_valid", sfx}, {63'd0, vout[d]}, 64'd0);
                check_eq({"rst_tag", sfx}, {48'd0, tout[d]}, 64'd0);
                check_eq({"rst_data", sfx}, dout[d], 64'd0);
            end else if (last_en) begin
                if (vout[d]) begin
                    if (sb[d].size() == 0) begin
                        check_eq({"spurious_valid", sfx}, {63'd0, vout[d]}, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        check_eq({"latency", sfx}, 64'(ecnt), 64'(e.due));
                        check_eq({"tag", sfx}, {48'd0, tout[d]}, {48'd0, e.tag});
                        check_eq({"data", sfx}, dout[d], e.data);
                    end
                end else if (sb[d].size() != 0 && sb[d][0].due <= ecnt) begin
                    check_eq({"missing_valid", sfx}, {63'd0, vout[d]}, 64'd1);
                    void'(sb[d].pop_front());
                end
            end else begin
                check_eq({"stall_valid", sfx}, {63'd0, vout[d]}, {63'd0, prev_v[d]});
                check_eq({"stall_tag", sfx}, {48'd0, tout[d]}, {48'd0, prev_t[d]});
                check_eq({"stall_data", sfx}, dout[d], prev_d[d]);
            end
            prev_d[d] = dout[d];
            prev_v[d] = vout[d];
            prev_t[d] = tout[d];
        end
    end

    // Drive one cycle of stimulus; expectations are pushed when an enabled read is presented.
    task automatic step(input logic e, input logic w, input logic [8:0] wa, input logic [63:0] wd,
                        input logic r, input logic [8:0] ra, input logic [15:0] rt,
                        input logic rs);
        en = e; wr_en = w; wr_addr = wa; wr_data = wd;
        rd_en = r; rd_addr = ra; rd_tag = rt; rst = rs;
        if (e && r && !rs) begin
            logic [63:0] xd;
            xd = model[ra];
`ifdef BRAM_RDW_FWD_EN
            if (w && wa == ra) xd = wd;
`endif
            for (int d = 0; d < NDUT; d++) begin
                exp_t x;
                x.data = xd;
                x.tag  = rt;
                x.due  = ecnt + LAT[d];
                sb[d].push_back(x);
            end
        end
        if (w) model[wa] = wd;
        @(posedge clk);
        if (rs) begin
            for (int d = 0; d < NDUT; d++) sb[d].delete();
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 16'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model[i] = 64'd0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 16'd0, 1'b1);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 16'd0, 1'b1);
        idle(2);

        // Pipelined write then tagged read
        step(1'b1, 1'b1, 9'd5, 64'h1111_0000_0000_0005, 1'b0, 9'd0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd5, 16'h0042, 1'b0);
        idle(6);

        // Stall mid-flight; inputs during the stall must be ignored
        step(1'b1, 1'b1, 9'd1, 64'hA1A1_0000_0000_0001, 1'b0, 9'd0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 9'd2, 64'hB2B2_0000_0000_0002, 1'b0, 9'd0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd1, 16'h0101, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd2, 16'h0202, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 9'd0, 64'd0, 1'b1, 9'(i + 3), 16'hDEAD, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 9'd0, 64'd0, 1'b0, 9'd1, 16'hBEEF, 1'b0);
        idle(4);

        // Reset with reads in flight; RAM must survive
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd1, 16'h0301, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd2, 16'h0302, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 16'd0, 1'b1);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd5, 16'h0305, 1'b0);
        idle(6);

        // Read-during-write on the same edge
        step(1'b1, 1'b1, 9'd9, 64'h0000_0000_0000_00AA, 1'b0, 9'd0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 9'd9, 64'h0000_0000_0000_00BB, 1'b1, 9'd9, 16'h0009, 1'b0);
        step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'd9, 16'h0019, 1'b0);
        idle(6);

        // Back-to-back reads
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 9'(i), 64'(i * 3), 1'b0, 9'd0, 16'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 9'd0, 64'd0, 1'b1, 9'(i), 16'(i), 1'b0);
        idle(8);

        for (int d = 0; d < NDUT; d++)
            check_eq($sformatf("sb_drain_L%0d", LAT[d]), 64'(sb[d].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
